// File: rtl/data_mem_if.sv
// Data-memory access responder: turns decode's load/store controls into a word-wide
// req/gnt/rvalid bus transaction and stalls the core until the access completes.
module data_mem_if #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_byte_i,
    input  logic              zero_extnd_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic              stall_o,
    output logic [31:0]       rd_data_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic             zext_q;
    logic             to_err_q;

    logic             misalign;
    logic             req_ok;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;

    // Handshake: a request is held on the bus (mem_req_o with stable addr/be/we/wdata)
    // until the cycle mem_gnt_i is seen high; load data is accepted on mem_rvalid_i
    // in that grant cycle or any later WAIT cycle.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        zext);
        logic [31:0] s;
        s = rdata >> {off, 3'b000};
        case (size)
            2'b00:   load_extend = {(zext ? 24'b0 : {24{s[7]}}), s[7:0]};
            2'b01:   load_extend = {(zext ? 16'b0 : {16{s[15]}}), s[15:0]};
            default: load_extend = rdata;
        endcase
    endfunction

    always_comb begin
        misalign   = 1'b0;
        be_next    = 4'b1111;
        wdata_next = data_wdata_i;
        case (data_byte_i)
            2'b00: begin
                be_next    = 4'b0001 << data_addr_i[1:0];
                wdata_next = {4{data_wdata_i[7:0]}};
            end
            2'b01: begin
                misalign   = data_addr_i[0];
                be_next    = 4'b0011 << data_addr_i[1:0];
                wdata_next = {2{data_wdata_i[15:0]}};
            end
            2'b10:   misalign = (data_addr_i[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    assign req_ok = data_req_i && !misalign;

    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            IDLE:    stall_o = req_ok;
            REQ:     stall_o = 1'b1;
            WAIT:    stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    // Misalign errors are flagged immediately; timeout errors are shown during DONE.
    assign err_o = rst_ni && (((state_q == IDLE) && data_req_i && misalign) ||
                              ((state_q == DONE) && to_err_q));

    assign state_o = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            zext_q      <= 1'b0;
            to_err_q    <= 1'b0;
            rd_data_o   <= 32'h0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_addr_o  <= '0;
            mem_wdata_o <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    to_err_q <= 1'b0;
                    if (req_ok) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= data_wr_i;
                        mem_be_o    <= be_next;
                        mem_addr_o  <= {data_addr_i[ADDR_W-1:2], 2'b00};
                        mem_wdata_o <= wdata_next;
                        size_q      <= data_byte_i;
                        off_q       <= data_addr_i[1:0];
                        zext_q      <= zero_extnd_i;
                        cnt_q       <= '0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (mem_we_o) begin
                            state_q <= DONE;
                        end else if (mem_rvalid_i) begin
                            rd_data_o <= load_extend(mem_rdata_i, size_q, off_q, zext_q);
                            state_q   <= DONE;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            state_q <= WAIT;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_o <= 1'b0;
                        rd_data_o <= 32'h0;
                        to_err_q  <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        rd_data_o <= load_extend(mem_rdata_i, size_q, off_q, zext_q);
                        state_q   <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        rd_data_o <= 32'h0;
                        to_err_q  <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    to_err_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_if.md
Name: data_mem_if

Overview:
Responder side of the core's data-access control interface. Consumes the request, write, size and zero-extend controls produced by decode, plus the ALU address and rs2 data. Runs a word-wide request/grant/response transaction on the data memory bus. Stalls the single-cycle core until completion and returns the aligned, sign- or zero-extended load result for register writeback.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT, 64, max cycles from entering REQ to completion before a bus error is flagged (>=2)

Ports:
clk_i  in  1  core clock
rst_ni  in  1  reset
data_req_i  in  1  memory access requested by current instruction
data_wr_i  in  1  1=store, 0=load
data_byte_i  in  2  size: 00=byte, 01=half, 10=word, 11=reserved
zero_extnd_i  in  1  zero-extend load result (LBU/LHU)
data_addr_i  in  ADDR_W  byte address from ALU
data_wdata_i  in  32  store data (rs2)
stall_o  out  1  hold PC/instruction this cycle
rd_data_o  out  32  extended load result, valid while in DONE
err_o  out  1  misalign or timeout error pulse
mem_req_o  out  1  bus request
mem_we_o  out  1  bus write enable
mem_be_o  out  4  byte lane enables
mem_addr_o  out  ADDR_W  word-aligned address (low 2 bits 0)
mem_wdata_o  out  32  lane-replicated store data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read data word

Behaviour:
- Reset is asynchronous and active-low on rst_ni; one clock, clk_i. On reset: state=IDLE; all mem_* outputs, rd_data_o, err_o = 0; stall_o=0 unless data_req_i is high (see IDLE).
- States: IDLE, REQ, WAIT, DONE.
- IDLE, no data_req_i: stall_o=0.
- IDLE, legal data_req_i: stall_o=1 combinationally. Latch word address, be, wdata, we, size, zext and offset=addr[1:0]. Next state REQ.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11. No bus transaction; err_o=1 and stall_o=0 in that same cycle; stay IDLE.
- mem_be_o:
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111
- mem_wdata_o:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- mem_* outputs are registered and held stable from REQ entry until grant.
- REQ: mem_req_o=1; stall_o=1.
  - Store on mem_gnt_i: go to DONE.
  - Load on mem_gnt_i with mem_rvalid_i=0: go to WAIT; mem_req_o drops next cycle.
  - Load with mem_gnt_i and mem_rvalid_i in the same cycle: capture data and go directly to DONE.
- WAIT: mem_req_o=0; stall_o=1. On mem_rvalid_i, capture the extended data into rd_data_o and go to DONE.
- Load extraction: s=mem_rdata_i>>(8*off).
  - byte: rd={zext?24'b0:{24{s[7]}}, s[7:0]}
  - half: same, on s[15:0]
  - word: mem_rdata_i
- DONE: stall_o=0 for exactly one cycle (core commits). rd_data_o holds its value. data_req_i is ignored this cycle. Next state IDLE.
  - rd_data_o is retained until the next load capture.
- Timeout: cycle counter cleared on REQ entry, counts in REQ and WAIT. When it reaches TIMEOUT-1 without completion:
  - mem_req_o=0; go to DONE with err_o=1 during DONE; rd_data_o=0.
  - A late mem_rvalid_i arriving in IDLE is ignored.
- mem_rvalid_i in IDLE or DONE: ignored.
- Reset mid-transaction: mem_req_o deasserts immediately (async); any outstanding response is dropped.
- Store writes use no rvalid; rd_data_o is unchanged by stores.

Test Plan:
- LW addr=0x104, rdata=0xDEADBEEF, gnt 1 cycle after REQ, rvalid 2 cycles later -> mem_addr_o=0x104, be=1111, stall_o high 4 cycles, DONE rd_data_o=0xDEADBEEF, err_o=0.
- LB addr=0x203, rdata=0x80xxxxxx -> be=1000, rd_data_o=0xFFFFFF80; same with LBU -> 0x00000080.
- SH addr=0x10A, wdata=0x1234ABCD, gnt same cycle as REQ -> mem_we_o=1, be=1100, mem_wdata_o=0xABCDABCD, DONE next cycle, rd_data_o unchanged.
- LW addr=0x102 -> err_o=1, stall_o=0 same cycle, mem_req_o never asserted.
- Load with gnt and rvalid both held low, TIMEOUT=64 -> mem_req_o drops after 64 cycles in REQ, DONE with err_o=1 and rd_data_o=0, then IDLE. A late rvalid is ignored.
- Assert rst_ni=0 while in WAIT -> mem_req_o/stall_o low, state IDLE. rvalid after release leaves rd_data_o=0.
